// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets two bus masters (A, B) share one
// synchronous-read RAM. Each access is a fixed four-cycle sequence, so the RAM
// sees at most one request per four cycles.
//
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   a_req/a_we/a_address/a_o_data    port A request, write flag, address, write data
//   a_i_data, a_ack           port A read data (held), one-cycle completion pulse
//   b_*                       same as port A, for port B
//   mem_address/mem_o_data/mem_we    registered RAM address, write data, write enable
//   mem_i_data                RAM read data, valid one cycle after the address
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; pick a winner and latch its request
// GRANT | mem_* stable; RAM samples address/data/we at the end of this cycle
// WAIT  | RAM read data on mem_i_data; capture it for the owner on a read
// DONE  | owner's ack high for this one cycle

module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_o_data,
  output logic [DATA_W-1:0] a_i_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_o_data,
  output logic [DATA_W-1:0] b_i_data,
  output logic              b_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_o_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_i_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  logic   last_b;    // 1: port B was served last, so A wins the next tie
  logic   owner_b;   // port owning the access in flight
  logic   is_write;  // access in flight is a write (mem_we is cleared after GRANT)

  // A wins when it requests alone, or on a tie when B was served last.
  logic grant_a;
  assign grant_a = a_req && (!b_req || last_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      owner_b     <= 1'b0;
      is_write    <= 1'b0;
      mem_address <= '0;
      mem_o_data  <= '0;
      mem_we      <= 1'b0;
      a_i_data    <= '0;
      b_i_data    <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            if (grant_a) begin
              owner_b     <= 1'b0;
              last_b      <= 1'b0;
              mem_address <= a_address;
              mem_o_data  <= a_o_data;
              mem_we      <= a_we;
              is_write    <= a_we;
            end else begin
              owner_b     <= 1'b1;
              last_b      <= 1'b1;
              mem_address <= b_address;
              mem_o_data  <= b_o_data;
              mem_we      <= b_we;
              is_write    <= b_we;
            end
            state <= GRANT;
          end
        end
        GRANT: begin
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (owner_b) begin
            if (!is_write) b_i_data <= mem_i_data;
            b_ack <= 1'b1;
          end else begin
            if (!is_write) a_i_data <= mem_i_data;
            a_ack <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
